// File: rtl/boot_reset_seq_pkg.sv
// Shared types and helpers for the boot/reset sequencer.
// The state enum, default stretch length and counter sizing live here.
package boot_pkg;

  typedef enum logic [1:0] {
    S_WAIT    = 2'd0,
    S_DL      = 2'd1,
    S_STRETCH = 2'd2,
    S_RUN     = 2'd3
  } state_t;

  localparam int DEF_STRETCH_CYCLES = 1024;

  // Bits needed to hold a down-counter that starts at n-1 (at least 1 bit).
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/boot_reset_seq_if.sv
// data_io download bus as seen by the sequencer: download level, image index, byte strobe.
interface boot_if;
  logic       ioctl_download;
  logic [7:0] ioctl_index;
  logic       ioctl_wr;

  modport master (output ioctl_download, ioctl_index, ioctl_wr);
  modport slave  (input  ioctl_download, ioctl_index, ioctl_wr);
endinterface

// File: rtl/boot_reset_seq_edge_det.sv
// Registered level follower with rise/fall strobes.
// The first cycle after reset only captures the input, so a level already high produces no rise.
module edge_det (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic armed;

  always_ff @(posedge clk) begin
    if (reset) begin
      q     <= 1'b0;
      armed <= 1'b0;
    end else begin
      q     <= d;
      armed <= 1'b1;
    end
  end

  assign rise = armed &  d & ~q;
  assign fall = armed & ~d &  q;

endmodule

// File: rtl/boot_reset_seq.sv
// Boot/reset sequencer: keeps the core in reset until the required images are loaded,
// stretches every reset request, and optionally holds reset during selected downloads.
module boot_reset_seq
  import boot_pkg::*;
#(
  parameter int                    NUM_IMAGES     = 4,
  parameter logic [NUM_IMAGES-1:0] REQ_MASK       = 4'b0001,
  parameter logic [NUM_IMAGES-1:0] HOLD_MASK      = 4'b0001,
  parameter int                    STRETCH_CYCLES = DEF_STRETCH_CYCLES,
  parameter int                    CNT_W          = 25
) (
  input  logic                  clk_sys,
  input  logic                  reset,
  boot_if.slave                 ioctl,
  input  logic                  req_reset,
  output logic                  core_reset,
  output logic [NUM_IMAGES-1:0] images_loaded,
  output logic                  all_required,
  output logic                  dl_active,
  output logic [CNT_W-1:0]      dl_bytes,
  output logic                  dl_empty
);

  localparam int            SW     = cnt_width(STRETCH_CYCLES);
  localparam logic [SW-1:0] RELOAD = SW'(STRETCH_CYCLES - 1);

  state_t                  state;
  state_t                  entry_state;
  logic [SW-1:0]           cnt;
  logic [7:0]              idx;
  logic                    dl_rise;
  logic                    dl_fall;
  logic                    idx_held;
  logic [NUM_IMAGES-1:0]   idx_onehot;
  logic [CNT_W-1:0]        bytes_inc;
  logic                    final_nz;
  logic [NUM_IMAGES-1:0]   loaded_upd;
  logic                    all_upd;

  edge_det u_dl_edge (
    .clk   (clk_sys),
    .reset (reset),
    .d     (ioctl.ioctl_download),
    .q     (dl_active),
    .rise  (dl_rise),
    .fall  (dl_fall)
  );

  // Out-of-range indices match no bit, so they are neither held nor recorded.
  always_comb begin
    idx_onehot = '0;
    idx_held   = 1'b0;
    for (int i = 0; i < NUM_IMAGES; i++) begin
      if (idx == 8'(i)) begin
        idx_onehot[i] = 1'b1;
        idx_held      = HOLD_MASK[i];
      end
    end
  end

  always_comb begin
    bytes_inc  = (dl_bytes == '1) ? dl_bytes : dl_bytes + CNT_W'(1);
    final_nz   = (dl_bytes != '0) || ioctl.ioctl_wr;
    loaded_upd = images_loaded | (final_nz ? idx_onehot : '0);
    all_upd    = (loaded_upd & REQ_MASK) == REQ_MASK;
  end

  assign all_required = (images_loaded & REQ_MASK) == REQ_MASK;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state         <= S_WAIT;
      entry_state   <= S_WAIT;
      core_reset    <= 1'b1;
      images_loaded <= '0;
      dl_bytes      <= '0;
      dl_empty      <= 1'b0;
      cnt           <= RELOAD;
      idx           <= '0;
    end else begin
      dl_empty <= 1'b0;

      // core_reset follows the state one cycle late; an unheld download keeps its entry value.
      case (state)
        S_WAIT, S_STRETCH: core_reset <= 1'b1;
        S_RUN:             core_reset <= 1'b0;
        S_DL:              if (idx_held) core_reset <= 1'b1;
        default:           core_reset <= 1'b1;
      endcase

      if (dl_rise) begin
        state       <= S_DL;
        entry_state <= state;
        idx         <= ioctl.ioctl_index;
        dl_bytes    <= '0;
      end else begin
        case (state)
          S_WAIT: begin
            if (all_required) begin
              state <= S_STRETCH;
              cnt   <= RELOAD;
            end
          end
          S_DL: begin
            if (ioctl.ioctl_wr) dl_bytes <= bytes_inc;
            if (dl_fall) begin
              images_loaded <= loaded_upd;
              dl_empty      <= ~final_nz;
              if (!all_upd) begin
                state <= S_WAIT;
              end else if (!idx_held && entry_state == S_RUN) begin
                state <= S_RUN;
              end else begin
                state <= S_STRETCH;
                cnt   <= RELOAD;
              end
            end
          end
          S_STRETCH: begin
            if (req_reset)        cnt   <= RELOAD;
            else if (cnt == '0)   state <= S_RUN;
            else                  cnt   <= cnt - SW'(1);
          end
          S_RUN: begin
            if (req_reset) begin
              state <= S_STRETCH;
              cnt   <= RELOAD;
            end
          end
          default: state <= S_WAIT;
        endcase
      end
    end
  end

endmodule

// File: doc/boot_reset_seq.md
Name: boot_reset_seq

Overview:
- Parametrised boot/reset sequencer for core wrappers.
- Replaces the ad-hoc "hold reset until the first download finishes" register.
- Tracks completion of up to NUM_IMAGES download images by ioctl_index and holds the core in reset until every image in REQ_MASK has loaded.
- Stretches every user or OSD reset request to a minimum pulse; optionally holds reset during downloads to selected indices.
- Sits between data_io/user_io and the core, in the data_io clock domain.

Parameters:
- NUM_IMAGES, 4, number of tracked download indices (0..NUM_IMAGES-1).
- REQ_MASK, 4'b0001, images that must be loaded before the core leaves reset.
- HOLD_MASK, 4'b0001, indices whose download holds core_reset high while in progress.
- STRETCH_CYCLES, 1024, minimum core_reset length after release conditions are met (>=1).
- CNT_W, 25, width of the written-byte counter.

Ports:
- clk_sys  in  1  system clock; same domain as data_io ioctl outputs.
- reset  in  1  synchronous, active-high; power-on/PLL-not-locked reset.
- ioctl_download  in  1  download in progress.
- ioctl_index  in  8  image index of the current download.
- ioctl_wr  in  1  one-cycle byte write strobe.
- req_reset  in  1  OR of OSD/button reset requests (level).
- core_reset  out  1  reset to the core.
- images_loaded  out  NUM_IMAGES  sticky per-index loaded flags.
- all_required  out  1  (images_loaded & REQ_MASK) == REQ_MASK.
- dl_active  out  1  registered ioctl_download.
- dl_bytes  out  CNT_W  bytes written in the current or last download (saturating).
- dl_empty  out  1  one-cycle pulse: a download ended with zero writes.

Behaviour:
- Under reset: state=WAIT, core_reset=1, images_loaded=0, dl_active=0, dl_bytes=0, dl_empty=0, stretch counter=STRETCH_CYCLES-1, latched index=0.
- Edge detect: dl_prev <= ioctl_download. The rise condition is ioctl_download & ~dl_prev; the fall condition is ~ioctl_download & dl_prev. dl_active = dl_prev.
- States: WAIT, DL, STRETCH, RUN.
- Rise, from any state: go to DL, latch ioctl_index, clear dl_bytes. A rise takes priority over the req_reset and counter logic in the same cycle.
- DL:
  - Each ioctl_wr increments dl_bytes, saturating at all-ones.
  - A write coinciding with the fall cycle is counted.
  - core_reset=1 if latched index < NUM_IMAGES and HOLD_MASK[idx]; otherwise core_reset keeps the value it had on entry to DL.
- Fall:
  - If the final count (including a same-cycle write) is >0 and idx < NUM_IMAGES, set images_loaded[idx]. An index >= NUM_IMAGES is counted but never recorded.
  - If the count is 0, pulse dl_empty for exactly one cycle and leave images_loaded unchanged.
  - Next state:
    - WAIT if !all_required (using the updated flags).
    - Else RUN if the index was not held and the state on entry to DL was RUN.
    - Else STRETCH with the counter reloaded.
- WAIT: core_reset=1. Go to STRETCH (counter reloaded) once all_required=1. This is also the path when REQ_MASK=0 and reset is deasserted.
- STRETCH:
  - core_reset=1; the counter decrements each cycle.
  - While req_reset=1, the counter reloads.
  - When the counter is 0 and req_reset=0, go to RUN next cycle.
  - core_reset is therefore high for at least STRETCH_CYCLES cycles after the last req_reset-high cycle.
- RUN: core_reset=0. If req_reset=1, go to STRETCH with the counter reloaded; core_reset rises the following cycle.
- core_reset is registered (one cycle after the state decision). No combinational path from inputs to outputs.
- images_loaded is sticky; only the reset port clears it (req_reset does not).
- Mid-operation reset: aborts any download tracking. A download still high when reset deasserts produces no rise, because dl_prev is taken from the input on the first post-reset cycle. The image is therefore not recorded until a fresh download starts.

Decomposition:
- Package boot_pkg: state enum typedef (WAIT, DL, STRETCH, RUN), default STRETCH_CYCLES constant, and a clog2-based counter-width function.
- One natural sub-module, edge_det: registered rise/fall detector, reused for ioctl_download.

Test Plan:
- Power-on with NUM_IMAGES=4, REQ_MASK=0001, STRETCH_CYCLES=16: release reset, download idx 0 with 100 writes → images_loaded=0001, dl_bytes=100, core_reset falls exactly 16+1 cycles after the fall edge.
- REQ_MASK=0011: load idx 0 only → core_reset stays 1 indefinitely. Then load idx 1 (3 writes) → all_required=1, core_reset releases after the stretch.
- In RUN, pulse req_reset for 5 cycles → core_reset high from the cycle after the first req_reset cycle until 16 cycles after its last high cycle. images_loaded unchanged.
- In RUN, download idx 2 (HOLD_MASK bit clear), 8 writes → core_reset stays 0 throughout, images_loaded[2]=1, state returns to RUN. Repeat with idx 0 → core_reset high during the download plus 16 cycles.
- Download idx 0 with zero writes → dl_empty pulses once, images_loaded unchanged. Download idx 9 with 4 writes → dl_bytes=4, no flag set. A write on the fall cycle is counted (e.g. 1 write exactly on the fall → dl_bytes=1, flag set).
- Assert reset mid-download (ioctl_download held high) → images_loaded=0, core_reset=1, no flag set when the download later falls. CNT_W=4 with 20 writes → dl_bytes saturates at 15.
